// File: rtl/tick_timestamp_if.sv
`default_nettype none
// ============================================================================
//  Module   : tick_timestamp_if
//  Purpose  : Valid/ready timestamp output channel of tick_timestamp.
//  Revision : 1.0 - initial release
// ============================================================================
interface tick_timestamp_if #(
    parameter int DATA_W = 26
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface
`default_nettype wire

// File: rtl/tick_timestamp.sv
`default_nettype none
// ============================================================================
//  Module   : tick_timestamp
//  Purpose  : {epoch, sub} time base from divider ticks, gap watchdog and
//             single-entry valid/ready timestamp capture register.
//  Revision : 1.0 - initial release
// ============================================================================
module tick_timestamp #(
    parameter int TICKS_PER_EPOCH = 1000,
    parameter int EPOCH_W         = 16,
    parameter int GAP_MAX         = 64
) (
    input  logic                  clk50,
    input  logic                  rst,
    input  logic                  pulse,
    input  logic                  clear,
    input  logic                  event_in,
    tick_timestamp_if.master      ts,
    output logic                  locked,
    output logic                  fault,
    output logic                  overflow
);
    localparam int SUB_W = $clog2(TICKS_PER_EPOCH);
    localparam int GAP_W = $clog2(GAP_MAX + 1);
    localparam int TS_W  = EPOCH_W + SUB_W;

    localparam logic [SUB_W-1:0] c_sub_last  = SUB_W'(TICKS_PER_EPOCH - 1);
    localparam logic [GAP_W-1:0] c_gap_limit = GAP_W'(GAP_MAX - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t             r_state;
    logic [SUB_W-1:0]   r_sub;
    logic [EPOCH_W-1:0] r_epoch;
    logic [GAP_W-1:0]   r_gap;
    logic               r_locked;
    logic               r_fault;
    logic               r_valid;
    logic [TS_W-1:0]    r_data;
    logic               r_overflow;

    // locked/fault are loaded alongside the state so they track it edge-for-edge
    always_ff @(posedge clk50 or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_sub    <= '0;
            r_epoch  <= '0;
            r_gap    <= '0;
            r_locked <= 1'b0;
            r_fault  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_gap <= '0;
                    if (pulse) begin
                        r_state  <= ST_RUN;
                        r_locked <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (pulse) begin
                        r_gap <= '0;
                        if (r_sub == c_sub_last) begin
                            r_sub   <= '0;
                            r_epoch <= r_epoch + EPOCH_W'(1);
                        end else begin
                            r_sub <= r_sub + SUB_W'(1);
                        end
                    end else if (r_gap == c_gap_limit) begin
                        r_state  <= ST_FAULT;
                        r_locked <= 1'b0;
                        r_fault  <= 1'b1;
                    end else begin
                        r_gap <= r_gap + GAP_W'(1);
                    end
                end
                ST_FAULT: begin
                    if (clear) begin
                        r_state <= ST_IDLE;
                        r_fault <= 1'b0;
                        r_sub   <= '0;
                        r_epoch <= '0;
                        r_gap   <= '0;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_locked <= 1'b0;
                    r_fault  <= 1'b0;
                end
            endcase
        end
    end

    // Capture uses pre-update counters, so a coincident pulse is not seen
    always_ff @(posedge clk50 or negedge rst) begin
        if (!rst) begin
            r_valid    <= 1'b0;
            r_data     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (event_in && (!r_valid || ts.ready)) begin
                r_valid <= 1'b1;
                r_data  <= {r_epoch, r_sub};
            end else if (ts.ready) begin
                r_valid <= 1'b0;
            end

            if (clear) begin
                r_overflow <= 1'b0;
            end else if (event_in && r_valid && !ts.ready) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign ts.valid = r_valid;
    assign ts.data  = r_data;
    assign locked   = r_locked;
    assign fault    = r_fault;
    assign overflow = r_overflow;
endmodule
`default_nettype wire

// File: tb/tb_tick_timestamp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tick_timestamp
//  Purpose  : Table-driven self-checking bench for tick_timestamp.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tick_timestamp;
    localparam int TPE   = 4;
    localparam int EW    = 16;
    localparam int GMAX  = 8;
    localparam int TS_W  = EW + $clog2(TPE);

    logic clk50 = 1'b0;
    logic rst;
    logic pulse, clear, event_in;
    logic locked, fault, overflow;

    tick_timestamp_if #(.DATA_W(TS_W)) ts ();

    tick_timestamp #(
        .TICKS_PER_EPOCH(TPE),
        .EPOCH_W        (EW),
        .GAP_MAX        (GMAX)
    ) dut (
        .clk50   (clk50),
        .rst     (rst),
        .pulse   (pulse),
        .clear   (clear),
        .event_in(event_in),
        .ts      (ts),
        .locked  (locked),
        .fault   (fault),
        .overflow(overflow)
    );

    always #5 clk50 = ~clk50;

    typedef struct {
        int              idle;
        bit              p, c, e, r, push;
        logic [TS_W-1:0] exp_data;
        bit              v, l, f, o;
    } vec_t;

    vec_t            vecs[$];
    logic [TS_W-1:0] sb[$];
    int              n_cmp = 0;
    int              n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [TS_W-1:0] tsv(input int ep, input int sub);
        return {EW'(ep), 2'(sub)};
    endfunction

    task automatic add(input int idle, input bit p, c, e, r, push,
                       input logic [TS_W-1:0] x, input bit v, l, f, o);
        vec_t t;
        t.idle = idle; t.p = p; t.c = c; t.e = e; t.r = r; t.push = push;
        t.exp_data = x; t.v = v; t.l = l; t.f = f; t.o = o;
        vecs.push_back(t);
    endtask

    // Transfer seen at the falling edge completes on the next rising edge
    always @(negedge clk50) begin
        if (rst && ts.valid && ts.ready) begin
            if (sb.size() == 0) begin
                chk("unexpected transfer", 32'(ts.data), 32'hFFFF_FFFF);
            end else begin
                chk("ts_data accepted", 32'(ts.data), 32'(sb.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; pulse = 1'b0; clear = 1'b0; event_in = 1'b0; ts.ready = 1'b0;

        //   idle p c e r push data       v l f o
        add(2,  0,0,1,1,1, tsv(0,0),  1,0,0,0);   // capture in IDLE
        add(4,  1,0,0,1,0, '0,        0,1,0,0);   // first pulse locks
        for (int i = 0; i < 5; i++)
            add(4, 1,0,0,1,0, '0,     0,1,0,0);   // pulses 2..6
        add(1,  0,0,1,1,1, tsv(1,1),  1,1,0,0);   // after 6 pulses
        add(2,  0,0,1,0,0, '0,        1,1,0,1);   // dropped under backpressure
        add(1,  1,0,0,0,0, '0,        1,1,0,1);   // sub -> 2 while held
        add(0,  0,0,0,1,0, '0,        0,1,0,1);   // ready alone drains
        add(0,  0,0,1,0,1, tsv(1,2),  1,1,0,1);
        add(1,  1,0,0,0,0, '0,        1,1,0,1);   // sub -> 3
        add(0,  0,0,1,1,1, tsv(1,3),  1,1,0,1);   // accept + recapture
        add(1,  0,1,0,1,0, '0,        0,1,0,0);   // clear in RUN
        add(3,  0,0,0,1,0, '0,        0,1,0,0);   // gap = 7, still RUN
        add(0,  0,0,0,1,0, '0,        0,0,1,0);   // 8th silent cycle -> FAULT
        add(1,  1,0,0,1,0, '0,        0,0,1,0);   // pulse ignored
        add(1,  0,0,1,1,1, tsv(1,3),  1,0,1,0);   // counters frozen
        add(0,  0,0,1,0,0, '0,        1,0,1,1);
        add(0,  0,1,0,1,0, '0,        0,0,0,0);   // clear FAULT -> IDLE
        add(2,  0,0,1,1,1, tsv(0,0),  1,0,0,0);
        add(2,  1,0,0,1,0, '0,        0,1,0,0);   // relock, sub 0
        add(7,  1,0,0,1,0, '0,        0,1,0,0);   // pulse at the gap limit wins
        add(2,  1,0,0,1,0, '0,        0,1,0,0);
        add(2,  1,0,0,1,0, '0,        0,1,0,0);   // sub 3
        add(0,  1,0,1,1,1, tsv(0,3),  1,1,0,0);   // event with pulse
        add(1,  0,0,1,1,1, tsv(1,0),  1,1,0,0);   // rolled over

        repeat (3) @(posedge clk50);
        #1;
        chk("reset ts_valid", 32'(ts.valid), 0);
        chk("reset ts_data",  32'(ts.data),  0);
        chk("reset locked",   32'(locked),   0);
        chk("reset fault",    32'(fault),    0);
        chk("reset overflow", 32'(overflow), 0);
        rst = 1'b1;

        foreach (vecs[k]) begin
            ts.ready = vecs[k].r;
            pulse = 1'b0; clear = 1'b0; event_in = 1'b0;
            repeat (vecs[k].idle) begin
                @(posedge clk50);
                #1;
            end
            pulse = vecs[k].p; clear = vecs[k].c; event_in = vecs[k].e;
            @(posedge clk50);
            #1;
            pulse = 1'b0; clear = 1'b0; event_in = 1'b0;
            if (vecs[k].push) sb.push_back(vecs[k].exp_data);
            chk($sformatf("row%0d ts_valid", k), 32'(ts.valid), 32'(vecs[k].v));
            chk($sformatf("row%0d locked", k),   32'(locked),   32'(vecs[k].l));
            chk($sformatf("row%0d fault", k),    32'(fault),    32'(vecs[k].f));
            chk($sformatf("row%0d overflow", k), 32'(overflow), 32'(vecs[k].o));
        end

        // Asynchronous reset while a capture is pending in RUN
        ts.ready = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("midrst ts_valid", 32'(ts.valid), 0);
        chk("midrst ts_data",  32'(ts.data),  0);
        chk("midrst locked",   32'(locked),   0);
        chk("midrst fault",    32'(fault),    0);
        chk("midrst overflow", 32'(overflow), 0);
        sb.delete();
        repeat (2) @(posedge clk50);
        #1;
        rst = 1'b1;

        event_in = 1'b1;
        @(posedge clk50);
        #1;
        event_in = 1'b0;
        sb.push_back(tsv(0,0));
        chk("post-reset ts_valid", 32'(ts.valid), 1);
        chk("post-reset locked",   32'(locked),   0);

        ts.ready = 1'b1;
        repeat (2) @(posedge clk50);
        #1;
        chk("drain ts_valid",   32'(ts.valid), 0);
        chk("scoreboard empty", 32'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/tick_timestamp.md
# tick_timestamp

Timestamp generator that sits directly downstream of the clock divider, consuming its one-cycle `pulse` tick in the `clk50` domain. It builds a two-level `{epoch, sub}` time base from those ticks and supervises the tick stream with a gap watchdog. On each `event_in` strobe it captures the current time into a single-entry valid/ready output register for downstream logic.

## Interface
- `TICKS_PER_EPOCH`, default 1000: ticks per epoch; `sub` wraps at this value; must be ≥2.
- `EPOCH_W`, default 16: epoch counter width.
- `GAP_MAX`, default 64: maximum `clk50` cycles allowed between ticks in RUN; must be ≥2.
- `SUB_W`, derived: `$clog2(TICKS_PER_EPOCH)`.
- `clk50`, input, 1: sole clock; all logic is rising-edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `pulse`, input, 1: tick from the divider; one `clk50` cycle wide, synchronous to `clk50`.
- `clear`, input, 1: one-cycle request that leaves FAULT for IDLE.
- `event_in`, input, 1: capture request, sampled each cycle.
- `ts_ready`, input, 1: downstream accepts `ts_data` when `ts_valid` && `ts_ready`.
- `ts_valid`, output, 1: captured timestamp pending.
- `ts_data`, output, EPOCH_W+SUB_W: captured `{epoch, sub}`.
- `locked`, output, 1: high in RUN.
- `fault`, output, 1: high in FAULT.
- `overflow`, output, 1: sticky flag for a dropped capture; cleared only by `rst` or `clear`.

## Operation
- **States:** IDLE, RUN, FAULT. Reset state is IDLE.
- **IDLE:**
  - `sub`, `epoch` and the gap counter are held at 0.
  - The first `pulse` moves the block to RUN. That pulse does not increment `sub`.
- **RUN:**
  - Each `pulse` increments `sub`.
  - When `sub` = TICKS_PER_EPOCH-1, a `pulse` sets `sub` to 0 and increments `epoch`.
  - `epoch` wraps modulo 2^EPOCH_W silently.
- **Gap watchdog (RUN only):**
  - `gap` resets to 0 on any cycle with `pulse`; otherwise it increments.
  - When `gap` would reach GAP_MAX without a `pulse`, the block enters FAULT.
  - A `pulse` on that same cycle wins: the block stays in RUN.
- **FAULT:**
  - `sub` and `epoch` are frozen and `pulse` is ignored.
  - `clear` moves the block to IDLE, zeroes `sub`, `epoch` and `gap`, and clears `overflow`.
  - `clear` in IDLE or RUN clears `overflow` only.
- **Capture:**
  - `event_in` captures in any state. It loads `ts_data` with the pre-update `{epoch, sub}` value and sets `ts_valid`.
  - If `event_in` and `pulse` occur together, the captured value is the value before the increment.
- **Output register:**
  - If `ts_valid`=1 and `ts_ready`=0, a new `event_in` is dropped, `overflow` is set, and `ts_data` is unchanged.
  - If `ts_valid`=1 and `ts_ready`=1 with `event_in`, the transfer completes and the new capture loads in the same cycle, so `ts_valid` stays 1.
  - `ts_ready` with no `event_in` clears `ts_valid`.
- **Reset mid-operation:** asserting `rst` immediately forces all state and outputs to reset values. Any pending `ts_data` is lost.

## Timing
- **Reset values:** `ts_valid`=0, `ts_data`=0, `locked`=0, `fault`=0, `overflow`=0.
- **Capture latency:** `event_in` at edge N gives `ts_valid`=1 with data after edge N (visible cycle N+1).
- **Counter update:** a `pulse` sampled at edge N updates `sub`/`epoch` after edge N.
- **State outputs:** `locked` and `fault` are registered from the state and change the cycle after the transition edge.
- **FAULT entry:** `fault` rises GAP_MAX cycles after the last `pulse` seen in RUN.
- **`ts_data` stability:** `ts_data` is stable whenever `ts_valid`=1 and `ts_ready`=0.
- **Combinational paths:** none from inputs to outputs.

## Test plan
- **Lock and count:** TICKS_PER_EPOCH=4, GAP_MAX=8; release `rst`, apply 6 pulses every 5 cycles.
  - Required: the first pulse sets `locked`=1 next cycle.
  - Required: `event_in` after the 6th pulse gives `ts_data`={epoch 1, sub 1}.
- **Simultaneous event and pulse:** `event_in` and `pulse` together when `sub`=3, `epoch`=0.
  - Required: `ts_data`={0,3}; the counters then read {1,0}.
- **Backpressure:** `ts_ready`=0 with two `event_in` 3 cycles apart.
  - Required: the first value is held, `overflow`=1, `ts_data` is unchanged.
  - Required: `ts_ready`=1 with no event clears `ts_valid` next cycle.
- **Accept and recapture:** `ts_valid`=1, then `ts_ready`=1 and `event_in`=1 in one cycle.
  - Required: `ts_valid` stays 1 and `ts_data` shows the new value.
- **Watchdog and clear:** stop pulses in RUN (GAP_MAX=8).
  - Required: `fault`=1 and `locked`=0 after 8 cycles; pulses in FAULT leave the counters unchanged.
  - Required: `clear` returns the block to IDLE with counters 0 and `overflow`=0; the next pulse gives `locked`=1.
- **Reset mid-operation:** assert `rst` low while `ts_valid`=1 in RUN.
  - Required: all outputs are 0 immediately, before the next clock edge, and the state is IDLE.
